// File: rtl/multicycle_cu_if.sv
// ----------------------------------------------------------------------------
// multicycle_cu_if
// Bundle between the multicycle control unit and its datapath / memories.
//
// Datapath -> control unit:
//    ins[31:0]            instruction word from instruction memory
//    ins_valid            ins is valid this cycle
//    br_taken             branch comparator result for current rs1/rs2
//    dm_ready             data memory finished the access
// Control unit -> datapath:
//    ir_load, pc_write    instruction register load, PC load from MUX1
//    rf_wenable           register-file write enable
//    dm_wenable, dm_req   data-memory write enable and request
//    rs1, rs2, rd, func3  registered decoded fields
//    subsra               subtract / arithmetic-shift select
//    mux_*_op             datapath mux selects
//    state[2:0], trap     current FSM state and sticky error flag
//
// Modport "master" is taken by the control unit (it commands the datapath),
// modport "slave" by the datapath side.
// ----------------------------------------------------------------------------
interface multicycle_cu_if;
   logic [31:0] ins;
   logic        ins_valid;
   logic        br_taken;
   logic        dm_ready;

   logic        ir_load;
   logic        pc_write;
   logic        rf_wenable;
   logic        dm_wenable;
   logic        dm_req;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [4:0]  rd;
   logic [2:0]  func3;
   logic        subsra;
   logic        mux_sum_alu_op;
   logic        mux_pc_reg1_op;
   logic        mux_imm_reg2_op;
   logic [1:0]  mux_dm_alu_sum_op;
   logic [2:0]  state;
   logic        trap;

   modport master (
      input  ins, ins_valid, br_taken, dm_ready,
      output ir_load, pc_write, rf_wenable, dm_wenable, dm_req,
      output rs1, rs2, rd, func3, subsra,
      output mux_sum_alu_op, mux_pc_reg1_op, mux_imm_reg2_op, mux_dm_alu_sum_op,
      output state, trap
   );

   modport slave (
      output ins, ins_valid, br_taken, dm_ready,
      input  ir_load, pc_write, rf_wenable, dm_wenable, dm_req,
      input  rs1, rs2, rd, func3, subsra,
      input  mux_sum_alu_op, mux_pc_reg1_op, mux_imm_reg2_op, mux_dm_alu_sum_op,
      input  state, trap
   );
endinterface

// File: rtl/multicycle_cu.sv
// ----------------------------------------------------------------------------
// multicycle_cu
// Control unit for a multicycle RV32 subset (R, I-ALU, load, store and,
// optionally, branch / JAL / JALR). Sequences FETCH, DECODE, EXEC, MEM, WB
// and BTGT, and parks in TRAP on an illegal opcode or a data-memory timeout.
//
// Parameters:
//    TIMEOUT    cycles allowed in MEM without dm_ready before trapping (1..255)
//    EN_BRANCH  1 = branch/JAL/JALR legal, 0 = they trap
// Ports:
//    clk        rising-edge clock
//    reset      asynchronous, active-low reset
//    bus        multicycle_cu_if.master (instruction/memory inputs,
//               datapath enables, decoded fields, mux selects, state, trap)
// ----------------------------------------------------------------------------
module multicycle_cu #(
   parameter int TIMEOUT   = 15,
   parameter bit EN_BRANCH = 1'b1
) (
   input logic            clk,
   input logic            reset,
   multicycle_cu_if.master bus
);

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;
   localparam logic [2:0] S_BTGT   = 3'd5;
   localparam logic [2:0] S_TRAP   = 3'd7;

   localparam logic [6:0] OPC_R    = 7'b0110011;
   localparam logic [6:0] OPC_I    = 7'b0010011;
   localparam logic [6:0] OPC_LD   = 7'b0000011;
   localparam logic [6:0] OPC_ST   = 7'b0100011;
   localparam logic [6:0] OPC_BR   = 7'b1100011;
   localparam logic [6:0] OPC_JAL  = 7'b1101111;
   localparam logic [6:0] OPC_JALR = 7'b1100111;

   // Instruction class remembered from DECODE so later states need not
   // look at the opcode again.
   localparam logic [2:0] CLS_R    = 3'd0;
   localparam logic [2:0] CLS_I    = 3'd1;
   localparam logic [2:0] CLS_LD   = 3'd2;
   localparam logic [2:0] CLS_ST   = 3'd3;
   localparam logic [2:0] CLS_BR   = 3'd4;
   localparam logic [2:0] CLS_JAL  = 3'd5;
   localparam logic [2:0] CLS_JALR = 3'd6;

   localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

   logic [2:0]  state_q, state_d;
   logic        trap_q, trap_d;
   logic [7:0]  wait_q, wait_d;
   logic [31:0] ir_q;
   logic [2:0]  cls_q;
   logic [4:0]  rs1_q, rs2_q, rd_q;
   logic [2:0]  func3_q;
   logic        subsra_q;

   logic [2:0]  decCls;
   logic        decLegal;
   logic        decSub;
   logic [7:0]  waitInc;

   logic        irLoad, pcWrite, rfWen, dmWen, dmReq;
   logic        sumAluOp, pcReg1Op, immReg2Op;
   logic [1:0]  dmSelOp;
   logic        func3Zero, subZero;

   logic        unusedIrBits;

   // Bits of the instruction word that carry only immediate payload and
   // never influence control.
   assign unusedIrBits = ^{ir_q[31], ir_q[29:25]};

   // Classify the latched instruction; branch-family opcodes are only
   // legal when the branch support is enabled.
   always_comb begin
      decCls   = CLS_R;
      decLegal = 1'b0;
      case (ir_q[6:0])
         OPC_R:    begin decCls = CLS_R;    decLegal = 1'b1;      end
         OPC_I:    begin decCls = CLS_I;    decLegal = 1'b1;      end
         OPC_LD:   begin decCls = CLS_LD;   decLegal = 1'b1;      end
         OPC_ST:   begin decCls = CLS_ST;   decLegal = 1'b1;      end
         OPC_BR:   begin decCls = CLS_BR;   decLegal = EN_BRANCH; end
         OPC_JAL:  begin decCls = CLS_JAL;  decLegal = EN_BRANCH; end
         OPC_JALR: begin decCls = CLS_JALR; decLegal = EN_BRANCH; end
         default:  begin decCls = CLS_R;    decLegal = 1'b0;      end
      endcase
   end

   // ins[30] selects SUB/SRA for R-type and SRAI (I-type, func3=101);
   // for every other instruction that bit is immediate data.
   assign decSub = ((ir_q[6:0] == OPC_R) ||
                    ((ir_q[6:0] == OPC_I) && (ir_q[14:12] == 3'b101))) ? ir_q[30] : 1'b0;

   assign waitInc = wait_q + 8'd1;

   // Next-state and control outputs. The ir_load request is gated by reset
   // so no enable leaks out while reset is held.
   always_comb begin
      state_d   = state_q;
      wait_d    = wait_q;
      irLoad    = 1'b0;
      pcWrite   = 1'b0;
      rfWen     = 1'b0;
      dmWen     = 1'b0;
      dmReq     = 1'b0;
      sumAluOp  = 1'b0;
      pcReg1Op  = 1'b0;
      immReg2Op = 1'b0;
      dmSelOp   = 2'b00;
      func3Zero = 1'b0;
      subZero   = 1'b0;
      case (state_q)
         S_FETCH: begin
            if (bus.ins_valid && reset) begin
               irLoad  = 1'b1;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            state_d = decLegal ? S_EXEC : S_TRAP;
         end
         S_EXEC: begin
            case (cls_q)
               CLS_R, CLS_I: begin
                  pcReg1Op  = 1'b1;
                  immReg2Op = (cls_q != CLS_R);
                  state_d   = S_WB;
               end
               CLS_LD, CLS_ST: begin
                  pcReg1Op  = 1'b1;
                  immReg2Op = 1'b1;
                  wait_d    = 8'd0;
                  state_d   = S_MEM;
               end
               CLS_BR: begin
                  pcReg1Op = 1'b1;
                  if (bus.br_taken) begin
                     state_d = S_BTGT;
                  end else begin
                     pcWrite = 1'b1;
                     state_d = S_FETCH;
                  end
               end
               CLS_JAL, CLS_JALR: begin
                  pcReg1Op  = (cls_q == CLS_JALR);
                  immReg2Op = 1'b1;
                  func3Zero = 1'b1;
                  state_d   = S_WB;
               end
               default: state_d = S_TRAP;
            endcase
         end
         S_MEM: begin
            dmReq = 1'b1;
            dmWen = (cls_q == CLS_ST);
            // A completion in the same cycle the counter would expire wins.
            if (bus.dm_ready) begin
               if (cls_q == CLS_ST) begin
                  pcWrite = 1'b1;
                  state_d = S_FETCH;
               end else begin
                  state_d = S_WB;
               end
            end else begin
               wait_d = waitInc;
               if (waitInc == TIMEOUT_C) begin
                  state_d = S_TRAP;
               end
            end
         end
         S_WB: begin
            pcWrite = 1'b1;
            rfWen   = (rd_q != 5'd0);
            case (cls_q)
               CLS_LD:            dmSelOp = 2'b00;
               CLS_JAL, CLS_JALR: dmSelOp = 2'b10;
               default:           dmSelOp = 2'b01;
            endcase
            sumAluOp = (cls_q == CLS_JAL) || (cls_q == CLS_JALR);
            state_d  = S_FETCH;
         end
         S_BTGT: begin
            immReg2Op = 1'b1;
            func3Zero = 1'b1;
            subZero   = 1'b1;
            pcWrite   = 1'b1;
            sumAluOp  = 1'b1;
            state_d   = S_FETCH;
         end
         S_TRAP: begin
            state_d = S_TRAP;
         end
         default: begin
            state_d = S_TRAP;
         end
      endcase
   end

   assign trap_d = trap_q | (state_d == S_TRAP);

   // State, wait counter, instruction register and decoded fields.
   // Fields are captured once in DECODE and held until the next DECODE.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_FETCH;
         trap_q   <= 1'b0;
         wait_q   <= 8'd0;
         ir_q     <= 32'd0;
         cls_q    <= CLS_R;
         rs1_q    <= 5'd0;
         rs2_q    <= 5'd0;
         rd_q     <= 5'd0;
         func3_q  <= 3'd0;
         subsra_q <= 1'b0;
      end else begin
         state_q <= state_d;
         trap_q  <= trap_d;
         wait_q  <= wait_d;
         if (irLoad) begin
            ir_q <= bus.ins;
         end
         if (state_q == S_DECODE) begin
            cls_q    <= decCls;
            rs1_q    <= ir_q[19:15];
            rs2_q    <= ir_q[24:20];
            rd_q     <= ir_q[11:7];
            func3_q  <= ir_q[14:12];
            subsra_q <= decSub;
         end
      end
   end

   assign bus.ir_load           = irLoad;
   assign bus.pc_write          = pcWrite;
   assign bus.rf_wenable        = rfWen;
   assign bus.dm_wenable        = dmWen;
   assign bus.dm_req            = dmReq;
   assign bus.rs1               = rs1_q;
   assign bus.rs2               = rs2_q;
   assign bus.rd                = rd_q;
   assign bus.func3             = func3Zero ? 3'b000 : func3_q;
   assign bus.subsra            = subZero ? 1'b0 : subsra_q;
   assign bus.mux_sum_alu_op    = sumAluOp;
   assign bus.mux_pc_reg1_op    = pcReg1Op;
   assign bus.mux_imm_reg2_op   = immReg2Op;
   assign bus.mux_dm_alu_sum_op = dmSelOp;
   assign bus.state             = state_q;
   assign bus.trap              = trap_q;

endmodule

// File: tb/tb_multicycle_cu.sv
// ----------------------------------------------------------------------------
// tb_multicycle_cu
// Directed bench for multicycle_cu. Two instances share the stimulus: one
// with TIMEOUT=4 and branches enabled, one with default TIMEOUT and branches
// disabled; "sel" picks which one is checked. Each instruction is expanded
// into its expected cycle-by-cycle trace from the instruction-level rules,
// and a single compare process checks every cycle against that trace.
// ----------------------------------------------------------------------------
module tb_multicycle_cu;

   localparam int TO_MAIN = 4;
   localparam int TO_NOBR = 15;

   typedef struct packed {
      logic [2:0] st;
      logic       irl, pcw, rfw, dmw, dmr, trp;
      logic [4:0] rs1, rs2, rd;
      logic [2:0] f3;
      logic       sub, sumAlu, pcReg1, immReg2;
      logic [1:0] dmSel;
   } outs_t;

   typedef struct packed {
      logic [4:0] rs1, rs2, rd;
      logic [2:0] f3;
      logic       sub;
   } fields_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] insIn = 32'd0;
   logic        insValidIn = 1'b0;
   logic        brIn = 1'b0;
   logic        readyIn = 1'b0;
   logic        sel = 1'b0;

   outs_t   expCur;
   logic    expValid = 1'b0;
   fields_t mf;
   int      vectors = 0;
   int      miscompares = 0;

   // 10-time-unit clock
   always #5 clk = ~clk;

   multicycle_cu_if busMain ();
   multicycle_cu_if busNoBr ();

   assign busMain.ins       = insIn;
   assign busMain.ins_valid = insValidIn;
   assign busMain.br_taken  = brIn;
   assign busMain.dm_ready  = readyIn;
   assign busNoBr.ins       = insIn;
   assign busNoBr.ins_valid = insValidIn;
   assign busNoBr.br_taken  = brIn;
   assign busNoBr.dm_ready  = readyIn;

   multicycle_cu #(.TIMEOUT(TO_MAIN), .EN_BRANCH(1'b1)) dutMain (
      .clk(clk), .reset(reset), .bus(busMain));
   multicycle_cu #(.TIMEOUT(TO_NOBR), .EN_BRANCH(1'b0)) dutNoBr (
      .clk(clk), .reset(reset), .bus(busNoBr));

   outs_t actMain, actNoBr, actSel;
   assign actMain = {busMain.state, busMain.ir_load, busMain.pc_write, busMain.rf_wenable,
                     busMain.dm_wenable, busMain.dm_req, busMain.trap, busMain.rs1, busMain.rs2,
                     busMain.rd, busMain.func3, busMain.subsra, busMain.mux_sum_alu_op,
                     busMain.mux_pc_reg1_op, busMain.mux_imm_reg2_op, busMain.mux_dm_alu_sum_op};
   assign actNoBr = {busNoBr.state, busNoBr.ir_load, busNoBr.pc_write, busNoBr.rf_wenable,
                     busNoBr.dm_wenable, busNoBr.dm_req, busNoBr.trap, busNoBr.rs1, busNoBr.rs2,
                     busNoBr.rd, busNoBr.func3, busNoBr.subsra, busNoBr.mux_sum_alu_op,
                     busNoBr.mux_pc_reg1_op, busNoBr.mux_imm_reg2_op, busNoBr.mux_dm_alu_sum_op};
   assign actSel = sel ? actNoBr : actMain;

   // Single comparison primitive: every check in the bench goes through here.
   task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic compareAll(input outs_t a, input outs_t e);
      checkOutput("state",      8'(a.st),      8'(e.st));
      checkOutput("ir_load",    8'(a.irl),     8'(e.irl));
      checkOutput("pc_write",   8'(a.pcw),     8'(e.pcw));
      checkOutput("rf_wenable", 8'(a.rfw),     8'(e.rfw));
      checkOutput("dm_wenable", 8'(a.dmw),     8'(e.dmw));
      checkOutput("dm_req",     8'(a.dmr),     8'(e.dmr));
      checkOutput("trap",       8'(a.trp),     8'(e.trp));
      checkOutput("rs1",        8'(a.rs1),     8'(e.rs1));
      checkOutput("rs2",        8'(a.rs2),     8'(e.rs2));
      checkOutput("rd",         8'(a.rd),      8'(e.rd));
      checkOutput("func3",      8'(a.f3),      8'(e.f3));
      checkOutput("subsra",     8'(a.sub),     8'(e.sub));
      checkOutput("sumAluSel",  8'(a.sumAlu),  8'(e.sumAlu));
      checkOutput("pcReg1Sel",  8'(a.pcReg1),  8'(e.pcReg1));
      checkOutput("immReg2Sel", 8'(a.immReg2), 8'(e.immReg2));
      checkOutput("dmAluSel",   8'(a.dmSel),   8'(e.dmSel));
   endtask

   // Compare process: sample mid-low-phase, well away from the rising edge.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (expValid) compareAll(actSel, expCur);
      end
   end

   // Expected outputs for a state with nothing asserted, fields as last decoded.
   function automatic outs_t base(input logic [2:0] st);
      outs_t o;
      o     = '0;
      o.st  = st;
      o.rs1 = mf.rs1;
      o.rs2 = mf.rs2;
      o.rd  = mf.rd;
      o.f3  = mf.f3;
      o.sub = mf.sub;
      return o;
   endfunction

   task automatic applyStimulus(input logic [31:0] i, input logic v, input logic b,
                                input logic r, input outs_t e);
      @(negedge clk);
      insIn      = i;
      insValidIn = v;
      brIn       = b;
      readyIn    = r;
      expCur     = e;
      expValid   = 1'b1;
   endtask

   task automatic trapCycles(input int n);
      outs_t e;
      for (int k = 0; k < n; k++) begin
         e     = base(3'd7);
         e.trp = 1'b1;
         applyStimulus(32'h0000_0033, 1'b1, 1'b1, 1'b1, e);
      end
   endtask

   task automatic wbCycle(input logic [1:0] dmSel, input logic jump);
      outs_t e;
      e        = base(3'd4);
      e.pcw    = 1'b1;
      e.rfw    = (mf.rd != 5'd0);
      e.dmSel  = dmSel;
      e.sumAlu = jump;
      applyStimulus(32'd0, 1'b0, 1'b0, 1'b0, e);
   endtask

   // Expand one instruction into its expected trace. readyAt = MEM cycle in
   // which dm_ready rises (0 = never); abortAt stops after that MEM cycle.
   task automatic runInstr(input logic [31:0] ins, input logic br, input int readyAt,
                           input bit enBr, input int timeout, input int abortAt);
      outs_t e;
      logic [6:0] opc;
      bit isR, isI, isL, isS, isB, isJal, isJalr, legal, rdy;
      opc    = ins[6:0];
      isR    = (opc == 7'b0110011);
      isI    = (opc == 7'b0010011);
      isL    = (opc == 7'b0000011);
      isS    = (opc == 7'b0100011);
      isB    = (opc == 7'b1100011);
      isJal  = (opc == 7'b1101111);
      isJalr = (opc == 7'b1100111);
      legal  = isR || isI || isL || isS || (enBr && (isB || isJal || isJalr));

      e     = base(3'd0);
      e.irl = 1'b1;
      applyStimulus(ins, 1'b1, 1'b0, 1'b0, e);
      // ins is withdrawn in DECODE: the unit must work from its latched copy
      e = base(3'd1);
      applyStimulus(32'd0, 1'b0, 1'b0, 1'b0, e);
      mf.rs1 = ins[19:15];
      mf.rs2 = ins[24:20];
      mf.rd  = ins[11:7];
      mf.f3  = ins[14:12];
      mf.sub = (isR || (isI && ins[14:12] == 3'b101)) ? ins[30] : 1'b0;
      if (!legal) begin
         trapCycles(3);
         return;
      end

      e = base(3'd2);
      if (isR || isI || isL || isS) begin
         e.pcReg1  = 1'b1;
         e.immReg2 = !isR;
         applyStimulus(32'd0, 1'b0, br, 1'b0, e);
         if (isR || isI) begin
            wbCycle(2'b01, 1'b0);
            return;
         end
         for (int k = 1; k <= timeout; k++) begin
            e     = base(3'd3);
            e.dmr = 1'b1;
            e.dmw = isS;
            rdy   = (k == readyAt);
            e.pcw = rdy && isS;
            applyStimulus(32'd0, 1'b0, 1'b0, rdy, e);
            if (k == abortAt) return;
            if (rdy) begin
               if (isL) wbCycle(2'b00, 1'b0);
               return;
            end
         end
         trapCycles(3);
      end else if (isB) begin
         e.pcReg1 = 1'b1;
         e.pcw    = !br;
         applyStimulus(32'd0, 1'b0, br, 1'b0, e);
         if (br) begin
            e         = base(3'd5);
            e.immReg2 = 1'b1;
            e.f3      = 3'b000;
            e.sub     = 1'b0;
            e.pcw     = 1'b1;
            e.sumAlu  = 1'b1;
            applyStimulus(32'd0, 1'b0, 1'b0, 1'b0, e);
         end
      end else begin
         e.pcReg1  = isJalr;
         e.immReg2 = 1'b1;
         e.f3      = 3'b000;
         applyStimulus(32'd0, 1'b0, br, 1'b0, e);
         wbCycle(2'b10, 1'b1);
      end
   endtask

   // Hold reset across a rising edge with every input active, then release
   // it just before the next low phase so the following edge is the first
   // FETCH evaluation.
   task automatic doReset();
      @(negedge clk);
      expValid   = 1'b0;
      reset      = 1'b0;
      insIn      = 32'hFFFF_FFFF;
      insValidIn = 1'b1;
      brIn       = 1'b1;
      readyIn    = 1'b1;
      #1;
      checkOutput("rstState",  8'(actSel.st),    8'd0);
      checkOutput("rstTrap",   8'(actSel.trp),   8'd0);
      checkOutput("rstIrLoad", 8'(actSel.irl),   8'd0);
      checkOutput("rstPcw",    8'(actSel.pcw),   8'd0);
      checkOutput("rstDmReq",  8'(actSel.dmr),   8'd0);
      checkOutput("rstRd",     8'(actSel.rd),    8'd0);
      checkOutput("rstRs1",    8'(actSel.rs1),   8'd0);
      checkOutput("rstDmSel",  8'(actSel.dmSel), 8'd0);
      @(posedge clk);
      #3;
      checkOutput("rstHoldState", 8'(actSel.st), 8'd0);
      reset      = 1'b1;
      insIn      = 32'd0;
      insValidIn = 1'b0;
      brIn       = 1'b0;
      readyIn    = 1'b0;
      mf         = '0;
   endtask

   initial begin
      outs_t e;
      mf  = '0;
      sel = 1'b0;
      doReset();

      // FETCH must idle while ins_valid is low
      for (int k = 0; k < 2; k++) begin
         e = base(3'd0);
         applyStimulus(32'h0020_81B3, 1'b0, 1'b0, 1'b0, e);
      end

      // add x3,x1,x2
      runInstr(32'h0020_81B3, 1'b0, 0, 1'b1, TO_MAIN, 0);
      #3;
      checkOutput("addWbState", 8'(actSel.st),    8'd4);
      checkOutput("addWbRd",    8'(actSel.rd),    8'd3);
      checkOutput("addWbRfw",   8'(actSel.rfw),   8'd1);
      checkOutput("addWbDmSel", 8'(actSel.dmSel), 8'd1);
      checkOutput("addWbPcw",   8'(actSel.pcw),   8'd1);

      runInstr(32'h4020_8133, 1'b0, 0, 1'b1, TO_MAIN, 0);   // sub x2,x1,x2
      #3 checkOutput("subSubsra", 8'(actSel.sub), 8'd1);
      runInstr(32'h4033_D313, 1'b0, 0, 1'b1, TO_MAIN, 0);   // srai x6,x7,3
      #3 checkOutput("sraiSubsra", 8'(actSel.sub), 8'd1);
      runInstr(32'hC000_0093, 1'b0, 0, 1'b1, TO_MAIN, 0);   // addi x1,x0,-1024
      #3 checkOutput("addiSubsra", 8'(actSel.sub), 8'd0);
      runInstr(32'h0000_0013, 1'b0, 0, 1'b1, TO_MAIN, 0);   // nop: rd=x0
      #3 checkOutput("nopRfw", 8'(actSel.rfw), 8'd0);

      // lw x5,8(x1), ready on the 3rd MEM cycle
      runInstr(32'h0080_A283, 1'b0, 3, 1'b1, TO_MAIN, 0);
      #3;
      checkOutput("lwWbState", 8'(actSel.st),    8'd4);
      checkOutput("lwWbRd",    8'(actSel.rd),    8'd5);
      checkOutput("lwWbDmSel", 8'(actSel.dmSel), 8'd0);

      // sw x2,4(x1), ready immediately
      runInstr(32'h0020_A223, 1'b0, 1, 1'b1, TO_MAIN, 0);
      #3;
      checkOutput("swMemDmw", 8'(actSel.dmw), 8'd1);
      checkOutput("swMemPcw", 8'(actSel.pcw), 8'd1);
      checkOutput("swMemRfw", 8'(actSel.rfw), 8'd0);

      // beq taken, then not taken
      runInstr(32'h0020_8463, 1'b1, 0, 1'b1, TO_MAIN, 0);
      #3;
      checkOutput("beqTState",  8'(actSel.st),     8'd5);
      checkOutput("beqTSumAlu", 8'(actSel.sumAlu), 8'd1);
      runInstr(32'h0020_8463, 1'b0, 0, 1'b1, TO_MAIN, 0);
      #3;
      checkOutput("beqNState", 8'(actSel.st),  8'd2);
      checkOutput("beqNPcw",   8'(actSel.pcw), 8'd1);

      // jal with non-zero bits in the func3 position, then jalr
      runInstr(32'h0000_D0EF, 1'b0, 0, 1'b1, TO_MAIN, 0);
      #3;
      checkOutput("jalDmSel",  8'(actSel.dmSel),  8'd2);
      checkOutput("jalSumAlu", 8'(actSel.sumAlu), 8'd1);
      runInstr(32'h0001_00E7, 1'b0, 0, 1'b1, TO_MAIN, 0);

      // ready arrives on the very cycle the counter reaches TIMEOUT
      runInstr(32'h0080_A283, 1'b0, TO_MAIN, 1'b1, TO_MAIN, 0);
      #3 checkOutput("edgeWbState", 8'(actSel.st), 8'd4);

      // never ready: trap after TIMEOUT MEM cycles
      runInstr(32'h0080_A283, 1'b0, 0, 1'b1, TO_MAIN, 0);
      #3;
      checkOutput("toState", 8'(actSel.st),  8'd7);
      checkOutput("toTrap",  8'(actSel.trp), 8'd1);
      doReset();

      // asynchronous reset in the middle of MEM
      runInstr(32'h0080_A283, 1'b0, 0, 1'b1, TO_MAIN, 1);
      @(posedge clk);
      #1;
      expValid = 1'b0;
      checkOutput("midMemState", 8'(actSel.st),  8'd3);
      checkOutput("midMemReq",   8'(actSel.dmr), 8'd1);
      reset = 1'b0;
      #1;
      checkOutput("asyncState", 8'(actSel.st),  8'd0);
      checkOutput("asyncTrap",  8'(actSel.trp), 8'd0);
      checkOutput("asyncReq",   8'(actSel.dmr), 8'd0);
      doReset();

      // illegal opcode
      runInstr(32'hFFFF_FFFF, 1'b0, 0, 1'b1, TO_MAIN, 0);
      #3;
      checkOutput("illState", 8'(actSel.st),  8'd7);
      checkOutput("illTrap",  8'(actSel.trp), 8'd1);

      // branches disabled: beq traps, add still runs
      sel = 1'b1;
      doReset();
      runInstr(32'h0020_8463, 1'b1, 0, 1'b0, TO_NOBR, 0);
      #3 checkOutput("noBrTrap", 8'(actSel.trp), 8'd1);
      doReset();
      runInstr(32'h0020_81B3, 1'b0, 0, 1'b0, TO_NOBR, 0);
      #3 checkOutput("noBrAddRd", 8'(actSel.rd), 8'd3);

      @(negedge clk);
      expValid = 1'b0;
      #3;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Absolute time limit so the run always ends on its own.
   initial begin
      #200000;
      miscompares++;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/multicycle_cu.md
MULTICYCLE_CU -- requirements
Module: multicycle_cu

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum cycles spent in MEM waiting for dm_ready; range 1..255.
REQ-002 Parameter EN_BRANCH, default 1: when 1, BRANCH (1100011), JAL (1101111) and JALR (1100111) are legal; when 0 they are illegal.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 ins  input  32  instruction word from instruction memory.
REQ-006 ins_valid  input  1  ins is valid this cycle.
REQ-007 br_taken  input  1  branch comparator result for the current rs1/rs2 operands.
REQ-008 dm_ready  input  1  data memory completed the access.
REQ-009 ir_load  output  1  latch ins into the instruction register.
REQ-010 pc_write  output  1  PC loads the MUX1 output.
REQ-011 rf_wenable, dm_wenable, dm_req  output  1 each  register-file write, data-memory write, data-memory request.
REQ-012 rs1, rs2, rd  output  5 each; func3  output  3; subsra  output  1: registered decoded fields.
REQ-013 mux_sum_alu_op, mux_pc_reg1_op, mux_imm_reg2_op  output  1 each; mux_dm_alu_sum_op  output  2 (00=DM, 01=ALU, 10=PC+4).
REQ-014 state  output  3  current FSM state; trap  output  1  sticky error flag.

Function
REQ-015 States SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, BTGT=5, TRAP=7; encoding 6 is unreachable and SHALL go to TRAP.
REQ-016 FETCH: wait for ins_valid; on ins_valid=1, assert ir_load for that cycle and go to DECODE.
REQ-017 DECODE: register rs1, rs2, rd and func3 from the latched instruction.
  - subsra = ins[30] for R-type; also = ins[30] for I-type with func3=101; otherwise 0.
  - Unsupported opcode -> TRAP; otherwise -> EXEC.
REQ-018 Supported opcodes: 0110011, 0010011, 0000011, 0100011, plus the REQ-002 set when EN_BRANCH=1.
REQ-019 EXEC, ALU and load/store: mux_pc_reg1_op=1; mux_imm_reg2_op=0 for R-type and 1 otherwise.
  - ALU types -> WB; load/store -> MEM.
REQ-020 EXEC, branch: mux_pc_reg1_op=1, mux_imm_reg2_op=0.
  - br_taken=0: pc_write=1, mux_sum_alu_op=0, -> FETCH.
  - br_taken=1: -> BTGT.
REQ-021 BTGT: mux_pc_reg1_op=0, mux_imm_reg2_op=1, func3 forced to 000, subsra=0, pc_write=1, mux_sum_alu_op=1, -> FETCH.
REQ-022 EXEC, JAL/JALR: mux_pc_reg1_op=0 for JAL and 1 for JALR; mux_imm_reg2_op=1; func3 forced to 000; -> WB.
REQ-023 MEM: assert dm_req every cycle while in MEM; dm_wenable=1 only for stores.
  - dm_ready=1, load: -> WB.
  - dm_ready=1, store: pc_write=1, mux_sum_alu_op=0, -> FETCH.
REQ-024 MEM timeout: an 8-bit wait counter clears on MEM entry and increments each cycle dm_ready=0. If it reaches TIMEOUT -> TRAP. If dm_ready=1 arrives in the same cycle the counter reaches TIMEOUT, completion wins.
REQ-025 WB: pc_write=1; rf_wenable=1 unless rd=0. mux_dm_alu_sum_op is 01 for ALU types, 00 for loads, 10 for JAL/JALR. mux_sum_alu_op is 1 for JAL/JALR and 0 otherwise. -> FETCH.
REQ-026 Every legal instruction SHALL assert pc_write exactly once and rf_wenable at most once.
REQ-027 TRAP: trap=1; ir_load, pc_write, rf_wenable, dm_wenable and dm_req all 0; exit only by reset.
REQ-028 All enables SHALL be 0 in any state and cycle not listed above.

Reset
REQ-029 reset=0 SHALL, asynchronously: set state=FETCH, trap=0, wait counter=0, all enables 0, all fields 0, all mux selects 0. This applies in any state, including mid-MEM.
REQ-030 The first FETCH evaluation SHALL occur on the first rising edge after reset deasserts.

Verification
REQ-031 0x002081B3 (add x3,x1,x2) -> states 0,1,2,4; in WB: rd=3, func3=0, subsra=0, rf_wenable=1, mux_dm_alu_sum_op=01, pc_write=1.
REQ-032 0x0080A283 (lw x5,8(x1)), dm_ready high on the 3rd MEM cycle -> dm_req high for 3 cycles, then WB with rd=5 and mux_dm_alu_sum_op=00.
REQ-033 0x0020A223 (sw x2,4(x1)), dm_ready immediate -> dm_wenable=1 and pc_write=1 in the same MEM cycle; rf_wenable never asserted.
REQ-034 0x00208463 (beq): br_taken=1 -> BTGT with mux_sum_alu_op=1; br_taken=0 -> pc_write in EXEC, BTGT skipped.
REQ-035 ins=0xFFFFFFFF -> TRAP after DECODE, trap=1 held; with EN_BRANCH=0, 0x00208463 also -> TRAP.
REQ-036 TIMEOUT=4, load with dm_ready=0 -> TRAP after 4 MEM cycles; reset pulsed mid-MEM -> FETCH immediately, trap=0, dm_req=0.
